phy_link_monitor: RTL

- Periodic PHY status poller that runs after PHY configuration has completed (init_done high).
- Drives the shared MDIO bit-shift engine in read mode:
  - BMSR (reg 1), then the PHY-specific status register (reg 17), once per poll period.
- Publishes link_up, speed and duplex to the MAC/UDP datapath, plus a link-change pulse and an MDIO timeout error.

---
 rtl/mdio_pkg.sv | 36 +++
 rtl/mdio_read_txn.sv | 99 +++++++++
 rtl/phy_link_monitor.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
// Shared MDIO definitions for the PHY status poller: register addresses,
// status-bit positions, speed encodings and the state types of the
// poller and of its single-read handshake engine.
package mdio_pkg;

  localparam logic [4:0] REG_BMCR    = 5'd0;
  localparam logic [4:0] REG_BMSR    = 5'd1;
  localparam logic [4:0] REG_PHYSTAT = 5'd17;

  localparam int BMSR_LINK     = 2;
  localparam int STAT_SPEED_HI = 15;
  localparam int STAT_SPEED_LO = 14;
  localparam int STAT_DUPLEX   = 13;
  localparam int STAT_RESOLVED = 11;

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_BMSR,
    ST_CLR_BMSR,
    ST_RD_STAT,
    ST_CLR_STAT,
    ST_UPDATE,
    ST_WAIT
  } mon_state_t;

  typedef enum logic [1:0] {
    TXN_IDLE,
    TXN_REQ,
    TXN_CLR
  } txn_state_t;

endpackage

// File: rtl/mdio_read_txn.sv
// One MDIO register read: raises mdio_start on go, waits for mdio_done,
// captures the read data, drops start and waits for done to fall again.
// A timeout counter restarts at the entry of each phase.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   go                launch a read (accepted when idle or while finishing)
//   reg_addr          register to read, latched on launch
//   mdio_start        engine request level
//   mdio_reg_addr     register address presented to the engine
//   mdio_done         engine completion level
//   mdio_rddata       engine read data
//   data              read data captured on the first done cycle
//   ok                combinational: done seen low again, read complete
//   err               combinational: timeout terminal count with no progress
module mdio_read_txn
  import mdio_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 200_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [4:0]  reg_addr,
  output logic        mdio_start,
  output logic [4:0]  mdio_reg_addr,
  input  logic        mdio_done,
  input  logic [15:0] mdio_rddata,
  output logic [15:0] data,
  output logic        ok,
  output logic        err
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

  txn_state_t  phase;
  logic [31:0] tcnt;
  logic        tc;

  assign tc = (tcnt == TO_LAST);
  assign ok = (phase == TXN_CLR) && !mdio_done;
  // done beats the terminal count when both land in the same cycle
  assign err = tc && (((phase == TXN_REQ) && !mdio_done) ||
                      ((phase == TXN_CLR) && mdio_done));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase         <= TXN_IDLE;
      tcnt          <= '0;
      mdio_start    <= 1'b0;
      mdio_reg_addr <= '0;
      data          <= '0;
    end else begin
      case (phase)
        TXN_IDLE: begin
          if (go) begin
            phase         <= TXN_REQ;
            tcnt          <= '0;
            mdio_start    <= 1'b1;
            mdio_reg_addr <= reg_addr;
          end
        end
        TXN_REQ: begin
          if (mdio_done) begin
            data       <= mdio_rddata;
            mdio_start <= 1'b0;
            tcnt       <= '0;
            phase      <= TXN_CLR;
          end else if (tc) begin
            mdio_start <= 1'b0;
            tcnt       <= '0;
            phase      <= TXN_IDLE;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        TXN_CLR: begin
          if (!mdio_done) begin
            tcnt <= '0;
            // back-to-back reads launch straight from the clear phase
            if (go) begin
              phase         <= TXN_REQ;
              mdio_start    <= 1'b1;
              mdio_reg_addr <= reg_addr;
            end else begin
              phase <= TXN_IDLE;
            end
          end else if (tc) begin
            tcnt  <= '0;
            phase <= TXN_IDLE;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        default: phase <= TXN_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/phy_link_monitor.sv
// Periodic PHY status poller. Once init_done is high it reads BMSR and the
// PHY-specific status register every poll period and publishes link, speed
// and duplex, a link-change pulse and an MDIO timeout flag.
//
// state       | meaning
// ------------+-----------------------------------------------
// IDLE        | polling disabled, waiting for init_done
// RD_BMSR     | BMSR read requested, waiting for done
// CLR_BMSR    | BMSR captured, waiting for done to fall
// RD_STAT     | status register read requested
// CLR_STAT    | status captured, waiting for done to fall
// UPDATE      | publish new link/speed/duplex (one cycle)
// WAIT        | poll period countdown
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   init_done           polling enable
//   mdio_start          engine request level
//   mdio_if_read        always 1
//   mdio_phy_addr       PHY address
//   mdio_reg_addr       register being read
//   mdio_done           engine completion level
//   mdio_rddata         engine read data
//   link_up, speed, full_duplex   resolved link status
//   status_valid        a poll has completed since reset/timeout
//   link_change         one-cycle pulse on link or speed change
//   mdio_err            last poll timed out
//   busy                a read handshake is in progress
module phy_link_monitor
  import mdio_pkg::*;
#(
  parameter int unsigned SYS_CLOCK   = 50_000_000,
  parameter int unsigned POLL_MS     = 100,
  parameter logic [4:0]  PHY_ADDR    = 5'b00001,
  parameter logic [4:0]  STAT_REG    = 5'd17,
  parameter int unsigned TIMEOUT_CYC = 200_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_done,
  output logic        mdio_start,
  output logic        mdio_if_read,
  output logic [4:0]  mdio_phy_addr,
  output logic [4:0]  mdio_reg_addr,
  input  logic        mdio_done,
  input  logic [15:0] mdio_rddata,
  output logic        link_up,
  output logic [1:0]  speed,
  output logic        full_duplex,
  output logic        status_valid,
  output logic        link_change,
  output logic        mdio_err,
  output logic        busy
);

  localparam int unsigned POLL_CYC  = SYS_CLOCK / 1000 * POLL_MS;
  localparam logic [31:0] POLL_LAST = 32'(POLL_CYC - 1);

  mon_state_t  state;
  logic [31:0] poll_cnt;
  logic        bmsr_link;
  logic        go;
  logic [4:0]  go_addr;
  logic        txn_ok;
  logic        txn_err;
  logic [15:0] txn_data;
  logic        new_link;
  logic [1:0]  new_speed;
  logic        unused_bits;

  assign mdio_if_read  = 1'b1;
  assign mdio_phy_addr = PHY_ADDR;
  assign busy = (state == ST_RD_BMSR) || (state == ST_CLR_BMSR) ||
                (state == ST_RD_STAT) || (state == ST_CLR_STAT);

  assign new_link    = bmsr_link & txn_data[STAT_RESOLVED];
  assign new_speed   = txn_data[STAT_SPEED_HI:STAT_SPEED_LO];
  assign unused_bits = ^{txn_data[12], txn_data[10:3], txn_data[1:0]};

  // Launch requests coincide with the transitions into RD_* below.
  always_comb begin
    go      = 1'b0;
    go_addr = REG_BMSR;
    case (state)
      ST_IDLE:     go = init_done;
      ST_WAIT:     go = init_done && (poll_cnt == POLL_LAST);
      ST_CLR_BMSR: begin
        go      = txn_ok && init_done;
        go_addr = STAT_REG;
      end
      default:     go = 1'b0;
    endcase
  end

  mdio_read_txn #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_txn (
    .clk           (clk),
    .rst_n         (rst_n),
    .go            (go),
    .reg_addr      (go_addr),
    .mdio_start    (mdio_start),
    .mdio_reg_addr (mdio_reg_addr),
    .mdio_done     (mdio_done),
    .mdio_rddata   (mdio_rddata),
    .data          (txn_data),
    .ok            (txn_ok),
    .err           (txn_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      poll_cnt     <= '0;
      bmsr_link    <= 1'b0;
      link_up      <= 1'b0;
      speed        <= SPD_10;
      full_duplex  <= 1'b0;
      status_valid <= 1'b0;
      link_change  <= 1'b0;
      mdio_err     <= 1'b0;
    end else begin
      link_change <= 1'b0;
      if (txn_err) begin
        // stalled engine: drop this poll, retry after a full period
        state        <= ST_WAIT;
        poll_cnt     <= '0;
        mdio_err     <= 1'b1;
        link_up      <= 1'b0;
        status_valid <= 1'b0;
        link_change  <= link_up;
      end else begin
        case (state)
          ST_IDLE: begin
            poll_cnt <= '0;
            if (init_done) state <= ST_RD_BMSR;
          end
          ST_RD_BMSR: begin
            if (mdio_done) state <= ST_CLR_BMSR;
          end
          ST_CLR_BMSR: begin
            if (txn_ok) begin
              bmsr_link <= txn_data[BMSR_LINK];
              if (init_done) begin
                state <= ST_RD_STAT;
              end else begin
                state        <= ST_IDLE;
                link_up      <= 1'b0;
                status_valid <= 1'b0;
              end
            end
          end
          ST_RD_STAT: begin
            if (mdio_done) state <= ST_CLR_STAT;
          end
          ST_CLR_STAT: begin
            if (txn_ok) begin
              if (init_done) begin
                state <= ST_UPDATE;
              end else begin
                state        <= ST_IDLE;
                link_up      <= 1'b0;
                status_valid <= 1'b0;
              end
            end
          end
          ST_UPDATE: begin
            link_up      <= new_link;
            speed        <= new_speed;
            full_duplex  <= txn_data[STAT_DUPLEX];
            status_valid <= 1'b1;
            mdio_err     <= 1'b0;
            link_change  <= (new_link != link_up) ||
                            (new_link && (new_speed != speed));
            poll_cnt     <= '0;
            state        <= ST_WAIT;
          end
          ST_WAIT: begin
            if (!init_done) begin
              state        <= ST_IDLE;
              link_up      <= 1'b0;
              status_valid <= 1'b0;
            end else if (poll_cnt == POLL_LAST) begin
              state <= ST_RD_BMSR;
            end else begin
              poll_cnt <= poll_cnt + 32'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
